// File: rtl/gray_pkg.sv
// gray_pkg: shared defaults and state type for the Gray conversion arbiter
package gray_pkg;
    localparam int NUM_DEF  = 6;
    localparam int NREQ_DEF = 4;
    localparam int ID_W_DEF = $clog2(NREQ_DEF);
    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: requester, result and handshake bus of the Gray conversion arbiter
interface gray_conv_arbiter_if import gray_pkg::*; #(
    parameter int NUM  = NUM_DEF,
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]               req_i;
    logic [NREQ-1:0][NUM-1:0]      bin_i;
    logic [NREQ-1:0]               ack_o;
    logic [NUM-1:0]                gray_o;
    logic [$clog2(NREQ)-1:0]       id_o;
    logic                          valid_o;
    logic                          ready_i;
    logic [7:0]                    cnt_o;
    modport slave (
        input  req_i, bin_i, ready_i,
        output ack_o, gray_o, id_o, valid_o, cnt_o
    );
    modport master (
        output req_i, bin_i, ready_i,
        input  ack_o, gray_o, id_o, valid_o, cnt_o
    );
endinterface

// File: rtl/bin2gray_core.sv
// bin2gray_core: combinational binary to reflected Gray code conversion
module bin2gray_core #(
    parameter int NUM = 6
) (
    input  logic [NUM-1:0] bin,
    output logic [NUM-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter feeding one Gray converter into a valid/ready output register
module gray_conv_arbiter import gray_pkg::*; #(
    parameter int NUM  = NUM_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input logic               clk,
    input logic               rst_n,
    gray_conv_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    state_t          state;
    logic [NUM-1:0]  gray_q;
    logic [NUM-1:0]  gray_w;
    logic [IW-1:0]   id_q;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   idx;
    logic [7:0]      cnt_q;
    logic            found;
    logic            accept;
    // search upward from ptr; IW-bit index arithmetic wraps NREQ-1 to 0
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + IW'(i);
            if (!found && bus.req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    assign accept = found && (state == EMPTY || bus.ready_i);
    bin2gray_core #(.NUM(NUM)) u_core (
        .bin  (bus.bin_i[win]),
        .gray (gray_w)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            gray_q <= '0;
            id_q   <= '0;
            ptr    <= '0;
            cnt_q  <= '0;
        end else begin
            if (state == FULL && bus.ready_i)
                cnt_q <= cnt_q + 8'd1;
            if (accept) begin
                state  <= FULL;
                gray_q <= gray_w;
                id_q   <= win;
                ptr    <= win + IW'(1);
            end else if (bus.ready_i) begin
                state <= EMPTY;
            end
        end
    end
    assign bus.ack_o   = (accept && rst_n) ? NREQ'(1) << win : '0;
    assign bus.gray_o  = gray_q;
    assign bus.id_o    = id_q;
    assign bus.valid_o = state == FULL;
    assign bus.cnt_o   = cnt_q;
endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter NUM, default 6: width of binary input and Gray output.
REQ-002 Parameter NREQ, default 4: number of requesters; power of two.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 req_i  input  NREQ: per-requester conversion request.
REQ-006 bin_i  input  NREQ x NUM: per-requester binary operand.
REQ-007 ack_o  output  NREQ: one-hot, single-cycle pulse marking the accepted request.
REQ-008 gray_o  output  NUM: registered Gray code result.
REQ-009 id_o  output  log2(NREQ): index of the requester that owns gray_o.
REQ-010 valid_o  output  1: gray_o and id_o hold a result.
REQ-011 ready_i  input  1: downstream consumes the result when valid_o and ready_i are both high.
REQ-012 cnt_o  output  8: count of results consumed downstream.

Function
REQ-013 Conversion: gray[NUM-1] = bin[NUM-1]; gray[i] = bin[i+1] XOR bin[i] for i = NUM-2 down to 0.
REQ-014 FSM has two states: EMPTY (valid_o = 0) and FULL (valid_o = 1); the reset state is EMPTY.
REQ-015 Accept condition: (|req_i) AND (state == EMPTY OR ready_i).
REQ-016 On accept, the winner is the first asserted req_i bit found searching upward from pointer ptr, wrapping from NREQ-1 to 0.
REQ-017 On accept, ack_o[winner] pulses in the same cycle, and the result plus id of the winner load into the output register on the next edge.
REQ-018 Latency: a request accepted in cycle N shows its result with valid_o = 1 in cycle N+1.
REQ-019 After a grant to k, ptr becomes (k+1) mod NREQ; without an accept, ptr holds.
REQ-020 Requesters hold req_i and bin_i stable until they see ack_o; the block samples bin_i only in the accept cycle.
REQ-021 FULL with ready_i = 0: gray_o, id_o and valid_o hold; no ack_o is issued.
REQ-022 FULL with ready_i = 1 and an accept: back-to-back transfer; valid_o stays 1 and the output register takes the new result.
REQ-023 FULL with ready_i = 1 and no request: go to EMPTY and drop valid_o on the next edge.
REQ-024 EMPTY with no request: stay in EMPTY; ack_o = 0.
REQ-025 cnt_o increments by 1 on each valid_o AND ready_i cycle and wraps from 255 to 0.
REQ-026 ready_i while in EMPTY has no effect.

Reset
REQ-027 rst_n low immediately forces: state EMPTY, valid_o 0, gray_o 0, id_o 0, ptr 0, cnt_o 0, ack_o 0.
REQ-028 Reset asserted mid-transfer discards the held result; no ack_o is issued for requests pending during reset.
REQ-029 The first accept may occur in the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package gray_pkg holds NUM_DEF = 6, NREQ_DEF = 4, the state enum (EMPTY, FULL) and the ID width constant.
REQ-031 The conversion is a combinational sub-module, bin2gray_core (parameter NUM), instantiated once on the muxed winner operand.
REQ-032 Arbitration, FSM, output register and counter are in gray_conv_arbiter itself.

Verification
REQ-033 Single request: req_i = 0001, bin_i[0] = 6'b101101, ready_i = 1 -> ack_o = 0001, then next cycle gray_o = 6'b111011, id_o = 0, valid_o = 1; cnt_o = 1 after the transfer.
REQ-034 Round-robin: req_i = 1111 held, ready_i = 1 -> ack_o sequence 0001, 0010, 0100, 1000, 0001 (ptr wraps); valid_o stays 1 continuously.
REQ-035 Backpressure: result bin 6'b000111 (gray 6'b000100) held with ready_i = 0 for 5 cycles -> gray_o, id_o and valid_o are stable and ack_o = 0; ready_i = 1 -> one transfer.
REQ-036 Drain with no request: FULL, req_i = 0, ready_i = 1 -> valid_o = 0 next cycle; bin 6'b111111 -> gray 6'b100000 checked before the drain.
REQ-037 Async reset: rst_n pulled low mid-cycle while FULL with bin 6'b010000 (gray 6'b011000) -> all outputs 0 before the next edge; after release, req_i = 0100 is granted first and ptr starts at 0.
REQ-038 Counter wrap: 256 consumed transfers -> cnt_o returns to 0.
